// File: rtl/pmbist_pkg.sv
// ---------------------------------------------------------------------------
// pmbist -- shared definitions for the PMBIST memory scheduler.
//   MEM_NUM        : number of memories behind the shared engine
//   MAX_PAR        : default limit on memories tested concurrently
//   sched_state_t  : scheduler FSM states
//   pick_group()   : lowest-index set bits of a pending mask, up to max_par
// ---------------------------------------------------------------------------
package pmbist;

    localparam int MEM_NUM = 4;
    localparam int MAX_PAR = 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_LAUNCH  = 3'd2,
        S_RUN     = 3'd3,
        S_COLLECT = 3'd4,
        S_DONE    = 3'd5
    } sched_state_t;

    // Walks upward from bit 0 so the lowest-index memories are tested first.
    function automatic logic [MEM_NUM-1:0] pick_group(
        input logic [MEM_NUM-1:0] pending,
        input int                 max_par
    );
        logic [MEM_NUM-1:0] grp;
        int                 cnt;
        grp = '0;
        cnt = 0;
        for (int i = 0; i < MEM_NUM; i++) begin
            if (pending[i] && (cnt < max_par)) begin
                grp[i] = 1'b1;
                cnt    = cnt + 1;
            end
        end
        return grp;
    endfunction

endpackage

// File: rtl/pmbist_sched_timer.sv
// ---------------------------------------------------------------------------
// pmbist_sched_timer -- RUN-state watchdog counter for the scheduler.
//   clk, rstn : clock, synchronous active-low reset
//   clr       : restart the count at zero (takes priority over en)
//   en        : count one cycle
//   expire    : high on the TIMEOUT_CYC-th enabled cycle since clr
// ---------------------------------------------------------------------------
module pmbist_sched_timer #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Decoded from the count register; en only qualifies the RUN state.
    assign expire = en && (cnt == LAST);

endmodule

// File: rtl/pmbist_mem_scheduler.sv
// ---------------------------------------------------------------------------
// pmbist_mem_scheduler -- sequences the shared PMBIST engine over MEM_NUM
// memories, at most MAX_PAR at a time, accumulating sticky fail results.
//
// Ports:
//   clk, rstn    : clock, synchronous active-low reset
//   start        : request a scheduled test (dropped while busy)
//   mem_mask     : memories to test, sampled on the accepted start
//   algo_done    : engine finished the march on the current group
//   fail_flags   : live per-memory compare-fail flags
//   eng_start    : one-cycle engine launch pulse
//   mem_sel      : test enable for the current group
//   fail_sticky  : accumulated per-memory fail result
//   busy         : scheduler not idle
//   done         : one-cycle end-of-schedule pulse
//   timeout_err  : sticky; a group exceeded TIMEOUT_CYC RUN cycles
//
// Build option: define PMBIST_SCHED_TIMEOUT_EN to add the RUN watchdog;
// without it RUN waits for algo_done indefinitely and timeout_err stays 0.
// ---------------------------------------------------------------------------
module pmbist_mem_scheduler
    import pmbist::*;
#(
    parameter int MEM_NUM     = pmbist::MEM_NUM,
    parameter int MAX_PAR     = pmbist::MAX_PAR,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [MEM_NUM-1:0] mem_mask,
    input  logic               algo_done,
    input  logic [MEM_NUM-1:0] fail_flags,
    output logic               eng_start,
    output logic [MEM_NUM-1:0] mem_sel,
    output logic [MEM_NUM-1:0] fail_sticky,
    output logic               busy,
    output logic               done,
    output logic               timeout_err
);

    sched_state_t       state;
    logic [MEM_NUM-1:0] pending;
    logic [MEM_NUM-1:0] group;
    logic [MEM_NUM-1:0] next_group;
    logic               timeout_hit;

    assign next_group = pick_group(pending, MAX_PAR);

`ifdef PMBIST_SCHED_TIMEOUT_EN
    // Cleared in LAUNCH so the count starts fresh on every RUN entry.
    pmbist_sched_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (state == S_LAUNCH),
        .en     (state == S_RUN),
        .expire (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= S_IDLE;
            pending     <= '0;
            group       <= '0;
            eng_start   <= 1'b0;
            mem_sel     <= '0;
            fail_sticky <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pending     <= mem_mask;
                        fail_sticky <= '0;
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (pending == '0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        group     <= next_group;
                        pending   <= pending & ~next_group;
                        eng_start <= 1'b1;
                        mem_sel   <= next_group;
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (algo_done) begin
                        fail_sticky <= fail_sticky | (fail_flags & group);
                        state       <= S_COLLECT;
                    end else if (timeout_hit) begin
                        // An unfinished group counts as failed in full.
                        fail_sticky <= fail_sticky | group;
                        timeout_err <= 1'b1;
                        state       <= S_COLLECT;
                    end else begin
                        fail_sticky <= fail_sticky | (fail_flags & group);
                    end
                end
                S_COLLECT: begin
                    fail_sticky <= fail_sticky | (fail_flags & group);
                    group       <= '0;
                    mem_sel     <= '0;
                    if (pending != '0) begin
                        state <= S_SELECT;
                    end else begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmbist_mem_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pmbist_mem_scheduler -- directed bench for pmbist_mem_scheduler
// (MEM_NUM=4, MAX_PAR=2, TIMEOUT_CYC=16). Expected groups are queued when a
// start is driven and popped when eng_start is seen.
// ---------------------------------------------------------------------------
module tb_pmbist_mem_scheduler;

    logic       clk;
    logic       rstn;
    logic       start;
    logic [3:0] mem_mask;
    logic       algo_done;
    logic [3:0] fail_flags;
    logic       eng_start;
    logic [3:0] mem_sel;
    logic [3:0] fail_sticky;
    logic       busy;
    logic       done;
    logic       timeout_err;

    int checks = 0;
    int passed = 0;
    int eng_cnt = 0;
    int done_cnt = 0;
    logic       tmo_skip = 1'b0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_grp;

    pmbist_mem_scheduler #(
        .MEM_NUM     (4),
        .MAX_PAR     (2),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .mem_mask    (mem_mask),
        .algo_done   (algo_done),
        .fail_flags  (fail_flags),
        .eng_start   (eng_start),
        .mem_sel     (mem_sel),
        .fail_sticky (fail_sticky),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Engine model: algo_done 10 cycles after each eng_start, unless the
    // next group is marked to be withheld.
    initial begin
        algo_done = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_start) begin
                if (tmo_skip) begin
                    tmo_skip = 1'b0;
                end else begin
                    repeat (10) @(negedge clk);
                    algo_done = 1'b1;
                    @(negedge clk);
                    algo_done = 1'b0;
                end
            end
        end
    end

    // Scoreboard: each launch must match the next queued group.
    always @(negedge clk) begin
        if (rstn && done) done_cnt++;
        if (rstn && eng_start) begin
            eng_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_launch", {28'd0, mem_sel}, 32'hFFFF);
            end else begin
                exp_grp = exp_q.pop_front();
                check("launch_group", {28'd0, mem_sel}, {28'd0, exp_grp});
            end
        end
    end

    task automatic do_start(input logic [3:0] m);
        @(negedge clk);
        start    = 1'b1;
        mem_mask = m;
        @(negedge clk);
        start    = 1'b0;
        mem_mask = 4'h0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, done}, 32'd1);
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check(tag, {27'd0, eng_start, busy, done, timeout_err, 1'b0},
              32'd0);
        check({tag, "_sel"}, {28'd0, mem_sel}, 32'd0);
        check({tag, "_sticky"}, {28'd0, fail_sticky}, 32'd0);
    endtask

    int e0, d0;

    initial begin
        rstn       = 1'b0;
        start      = 1'b0;
        mem_mask   = 4'h0;
        fail_flags = 4'h0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rstn = 1'b1;

        // Group split: 1111 -> 0011 then 1100.
        e0 = eng_cnt; d0 = done_cnt;
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b1100);
        do_start(4'b1111);
        check("split_busy_c1", {30'd0, busy, eng_start}, 32'b10);
        @(negedge clk);
        check("split_launch_c2", {27'd0, eng_start, mem_sel}, {27'd1, 4'b0011});
        wait_done("split_done", 100);
        check("split_eng_cnt", eng_cnt - e0, 2);
        check("split_done_cnt", done_cnt - d0, 1);
        check("split_sticky", {28'd0, fail_sticky}, 32'd0);
        check("split_q_empty", exp_q.size(), 0);
        check("split_idle", {30'd0, busy, |mem_sel}, 32'd0);

        // Fail capture: bit 2 pulsed in RUN, bit 1 (outside group) always on.
        fail_flags = 4'b0010;
        exp_q.push_back(4'b0101);
        do_start(4'b0101);
        @(negedge clk);
        @(negedge clk);
        fail_flags = 4'b0110;
        @(negedge clk);
        fail_flags = 4'b0010;
        wait_done("fail_done", 100);
        check("fail_sticky", {28'd0, fail_sticky}, 32'b0100);
        repeat (5) @(negedge clk);
        check("fail_sticky_hold", {28'd0, fail_sticky}, 32'b0100);
        fail_flags = 4'b0000;

        // Empty mask.
        e0 = eng_cnt;
        do_start(4'b0000);
        check("empty_c1", {30'd0, busy, done}, 32'b10);
        @(negedge clk);
        check("empty_c2", {30'd0, busy, done}, 32'b11);
        @(negedge clk);
        check("empty_c3", {30'd0, busy, done}, 32'b00);
        check("empty_no_launch", eng_cnt - e0, 0);
        check("empty_sticky_clr", {28'd0, fail_sticky}, 32'd0);

        // Start while busy is dropped.
        e0 = eng_cnt; d0 = done_cnt;
        exp_q.push_back(4'b0011);
        do_start(4'b0011);
        repeat (4) @(negedge clk);
        do_start(4'b1100);
        wait_done("busy_done", 100);
        repeat (20) @(negedge clk);
        check("busy_eng_cnt", eng_cnt - e0, 1);
        check("busy_done_cnt", done_cnt - d0, 1);
        check("busy_q_empty", exp_q.size(), 0);

        // Reset in the middle of RUN.
        exp_q.push_back(4'b0011);
        do_start(4'b1111);
        repeat (3) @(negedge clk);
        fail_flags = 4'b0001;
        @(negedge clk);
        fail_flags = 4'b0000;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check_idle_outputs("midrun_reset");
        repeat (20) @(negedge clk);
        check("midrun_still_idle", {31'd0, busy}, 32'd0);
        e0 = eng_cnt; d0 = done_cnt;
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b1100);
        do_start(4'b1111);
        wait_done("rerun_done", 100);
        check("rerun_eng_cnt", eng_cnt - e0, 2);
        check("rerun_done_cnt", done_cnt - d0, 1);
        check("rerun_sticky", {28'd0, fail_sticky}, 32'd0);

`ifdef PMBIST_SCHED_TIMEOUT_EN
        // Timeout: first group never completes.
        e0 = eng_cnt;
        tmo_skip = 1'b1;
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b1100);
        do_start(4'b1111);
        @(negedge clk);
        check("tmo_launch", {31'd0, eng_start}, 32'd1);
        repeat (16) @(negedge clk);
        check("tmo_not_yet", {31'd0, timeout_err}, 32'd0);
        @(negedge clk);
        check("tmo_err_set", {31'd0, timeout_err}, 32'd1);
        check("tmo_sticky_grp1", {28'd0, fail_sticky}, 32'b0011);
        wait_done("tmo_done", 100);
        check("tmo_eng_cnt", eng_cnt - e0, 2);
        check("tmo_sticky_final", {28'd0, fail_sticky}, 32'b0011);
        check("tmo_err_hold", {31'd0, timeout_err}, 32'd1);
`else
        check("no_tmo_err", {31'd0, timeout_err}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
